// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one 4-bit ALU between N requesters.
// One operation in flight: accept -> enable pulse -> sample -> respond.
module alu_arbiter #(
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  input  logic [4*N-1:0]    req_a,
  input  logic [4*N-1:0]    req_b,
  input  logic [2*N-1:0]    req_op,
  output logic [N-1:0]      req_ready,
  output logic [N-1:0]      resp_valid,
  output logic [7:0]        resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [1:0]        alu_opcode,
  output logic              alu_en,
  input  logic [7:0]        alu_out,
  input  logic              alu_done
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, SAMPLE, RESP} state_e;

  state_e            state_q, state_d;
  logic [GW-1:0]     last_q, last_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [3:0]        alu_a_q, alu_a_d;
  logic [3:0]        alu_b_q, alu_b_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic              alu_en_q, alu_en_d;
  logic [N-1:0]      resp_valid_q, resp_valid_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic              resp_err_q, resp_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              pick_vld;
  logic [GW-1:0]     pick;

  // Search starts one past the last grant and wraps; first hit wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = last_q;
    for (int k = 1; k <= N; k++) begin
      if (!pick_vld && req_valid[(int'(last_q) + k) % N]) begin
        pick_vld = 1'b1;
        pick     = GW'((int'(last_q) + k) % N);
      end
    end
  end

  // Accept strobe is combinational so the requester sees it in the grant cycle.
  assign req_ready = (rst_n && state_q == IDLE && pick_vld) ? (N'(1) << pick) : '0;

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_en_d     = 1'b0;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d    = pick;
          alu_a_d  = req_a[4*int'(pick) +: 4];
          alu_b_d  = req_b[4*int'(pick) +: 4];
          alu_op_d = req_op[2*int'(pick) +: 2];
          alu_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = SAMPLE;
      SAMPLE: begin
        resp_data_d  = alu_out;
        resp_err_d   = ~alu_done;
        resp_valid_d = N'(1) << gnt_q;
        op_count_d   = op_count_q + CNT_W'(1);
        state_d      = RESP;
      end
      RESP: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= GW'(N - 1);
      gnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_en_q     <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_en_q     <= alu_en_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign op_count   = op_count_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign alu_en     = alu_en_q;

endmodule
